// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock parametrised FIFO.
package sync_fifo_pkg;

    localparam int ERR_CNT_W = 16;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one write port, one read port with a registered,
// enable-held output. No reset on either the array or the read register.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy level, threshold flags and error pulses.
// Define SYNC_FIFO_ERR_CNT_EN to add saturating overflow/underflow counters.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     r_en,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     write_error,
    output logic                     read_error
`ifdef SYNC_FIFO_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]     ovf_cnt,
    output logic [ERR_CNT_W-1:0]     udf_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_L    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_L    = (AW+1)'(AE_LEVEL);

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 4");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_param: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_param: AE_LEVEL out of range");
    end

    logic [AW-1:0]         wptr, rptr;
    logic [AW:0]           level_nxt;
    logic                  wr_ok, rd_ok;
    logic                  rd_seen;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Acceptance uses start-of-cycle flags; requests are dropped during reset.
    assign wr_ok = w_en & ~full  & ~rst;
    assign rd_ok = r_en & ~empty & ~rst;

    always_comb begin
        level_nxt = level;
        if (wr_ok && !rd_ok)      level_nxt = level + 1'b1;
        else if (!wr_ok && rd_ok) level_nxt = level - 1'b1;
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (data_in),
        .re    (rd_ok),
        .raddr (rptr),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset, so output zero until the first read lands.
    assign data_out = rd_seen ? ram_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            rd_seen      <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            write_error  <= 1'b0;
            read_error   <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) begin
                rptr    <= rptr + 1'b1;
                rd_seen <= 1'b1;
            end
            level        <= level_nxt;
            full         <= (level_nxt == DEPTH_L);
            empty        <= (level_nxt == '0);
            almost_full  <= (level_nxt >= AF_L);
            almost_empty <= (level_nxt <= AE_L);
            write_error  <= w_en & full;
            read_error   <= r_en & empty;
        end
    end

`ifdef SYNC_FIFO_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else begin
            if (w_en && full && ovf_cnt != '1)  ovf_cnt <= ovf_cnt + 1'b1;
            if (r_en && empty && udf_cnt != '1) udf_cnt <= udf_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (8-bit x 16, AF=12, AE=2).
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst, w_en, r_en;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] level;
    logic       write_error, read_error;
`ifdef SYNC_FIFO_ERR_CNT_EN
    logic [15:0] ovf_cnt, udf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .AF_LEVEL   (12),
        .AE_LEVEL   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_en         (w_en),
        .data_in      (data_in),
        .r_en         (r_en),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .write_error  (write_error),
        .read_error   (read_error)
`ifdef SYNC_FIFO_ERR_CNT_EN
        ,
        .ovf_cnt      (ovf_cnt),
        .udf_cnt      (udf_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input int lvl);
        chk({tag, " level"}, 32'(level), 32'(lvl));
        chk({tag, " full"}, 32'(full), 32'(lvl == 16));
        chk({tag, " empty"}, 32'(empty), 32'(lvl == 0));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(lvl >= 12));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(lvl <= 2));
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
        step(); step();
        rst = 1'b0;
        chk_flags("reset", 0);
        chk("reset data_out", 32'(data_out), 32'h0);
        chk("reset write_error", 32'(write_error), 32'h0);
        chk("reset read_error", 32'(read_error), 32'h0);

        // 1: fill 0x01..0x10, then drain in order
        for (int i = 1; i <= 16; i++) begin
            w_en = 1'b1; data_in = 8'(i);
            step();
            chk_flags("fill", i);
        end
        w_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            r_en = 1'b1;
            step();
            chk("drain data_out", 32'(data_out), 32'(i));
            chk("drain level", 32'(level), 32'(16 - i));
        end
        r_en = 1'b0;
        chk_flags("drained", 0);

        // 2: overflow attempt while full
        for (int i = 1; i <= 16; i++) begin
            w_en = 1'b1; data_in = 8'(8'h20 + i);
            step();
        end
        data_in = 8'hAA;
        step();
        chk("ovf write_error", 32'(write_error), 32'h1);
        chk("ovf level", 32'(level), 32'd16);
        w_en = 1'b0;
        step();
        chk("ovf pulse end", 32'(write_error), 32'h0);
        chk("ovf level hold", 32'(level), 32'd16);
`ifdef SYNC_FIFO_ERR_CNT_EN
        chk("ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
        for (int i = 1; i <= 16; i++) begin
            r_en = 1'b1;
            step();
            chk("ovf drain data", 32'(data_out), 32'(8'h20 + i));
        end
        r_en = 1'b0;

        // 3: underflow attempt with a simultaneous write
        r_en = 1'b1; w_en = 1'b1; data_in = 8'h55;
        step();
        chk("udf read_error", 32'(read_error), 32'h1);
        chk("udf level", 32'(level), 32'd1);
        chk("udf data_out held", 32'(data_out), 32'h30);
        w_en = 1'b0;
        step();
        chk("udf readback", 32'(data_out), 32'h55);
        chk("udf pulse end", 32'(read_error), 32'h0);
        chk("udf level after", 32'(level), 32'd0);
`ifdef SYNC_FIFO_ERR_CNT_EN
        chk("udf_cnt", 32'(udf_cnt), 32'd1);
`endif
        r_en = 1'b0;

        // 4: streaming at level 8 with pointer wrap
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; data_in = 8'(8'h80 + i);
            step();
        end
        chk("stream prefill", 32'(level), 32'd8);
        for (int c = 0; c < 40; c++) begin
            w_en = 1'b1; r_en = 1'b1; data_in = 8'(8'h88 + c);
            step();
            chk("stream data", 32'(data_out), 32'(8'h80 + c));
            chk("stream level", 32'(level), 32'd8);
            chk("stream errs", 32'({write_error, read_error}), 32'h0);
        end
        r_en = 1'b0;

        // 5: reset mid-operation at level 10
        data_in = 8'hC0; step();
        data_in = 8'hC1; step();
        chk("pre-reset level", 32'(level), 32'd10);
        rst = 1'b1; w_en = 1'b1; r_en = 1'b1;
        step();
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
        chk_flags("mid reset", 0);
        chk("mid reset data_out", 32'(data_out), 32'h0);
        chk("mid reset errs", 32'({write_error, read_error}), 32'h0);
`ifdef SYNC_FIFO_ERR_CNT_EN
        chk("mid reset cnts", 32'({ovf_cnt, udf_cnt}), 32'h0);
`endif
        step();
        chk_flags("post reset idle", 0);

        // 6: threshold sweep up and back down
        for (int i = 1; i <= 16; i++) begin
            w_en = 1'b1; data_in = 8'(i);
            step();
            chk_flags("sweep up", i);
        end
        w_en = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            r_en = 1'b1;
            step();
            chk_flags("sweep down", i);
        end
        r_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
